// File: rtl/game_ctrl_pkg.sv
// Shared types for the GameControl spawn path: controller states, random
// source width and the lane-index type used by the game FSM.
package game_ctrl_pkg;

  localparam int RAND_W     = 4;
  localparam int LANE_MAX_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COUNT   = 3'd1,
    REQ     = 3'd2,
    SAMPLE  = 3'd3,
    PRESENT = 3'd4
  } spawn_state_e;

  typedef logic [RAND_W-1:0]     rand_t;
  typedef logic [LANE_MAX_W-1:0] lane_t;

endpackage

// File: rtl/spawn_timer.sv
// Loadable down-counter with a zero flag; saturates at zero so it never wraps.
module spawn_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/rand_spawn_ctrl.sv
// Spawn pacing and lane selection from the 4-bit LFSR by rejection sampling.
// Optional: define NO_REPEAT_LANE_EN to reject a candidate equal to the last lane.
module rand_spawn_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int NUM_LANES    = 6,
  parameter int SPAWN_PERIOD = 1000,
  parameter int MAX_RETRY    = 4,
  parameter int LANE_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [RAND_W-1:0] i_rand,
  output logic              o_rand_req,
  output logic              o_spawn_valid,
  input  logic              i_spawn_ready,
  output logic [LANE_W-1:0] o_spawn_lane,
  output logic              o_fallback
);

  localparam int TMR_W   = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  spawn_state_e       state_q, state_n;
  logic [RETRY_W-1:0] retry_q, retry_n;
  logic [LANE_W-1:0]  lane_q, lane_n;
  logic [LANE_W-1:0]  last_lane_q, last_lane_n;
  logic               fb_q, fb_n;
  logic               tmr_load, tmr_dec, tmr_zero;

  logic               in_range;
  logic               cand_ok;
  logic [LANE_W-1:0]  cand_lane;
  logic [LANE_W-1:0]  fb_lane;

  spawn_timer #(
    .W (TMR_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (tmr_load),
    .i_load_val (TMR_W'(SPAWN_PERIOD - 1)),
    .i_dec      (tmr_dec),
    .o_zero     (tmr_zero)
  );

  assign in_range  = (i_rand != '0) && ({1'b0, i_rand} <= 5'(NUM_LANES));
  assign cand_lane = LANE_W'(i_rand - RAND_W'(1));
  assign fb_lane   = (last_lane_q == LANE_W'(NUM_LANES - 1)) ? '0
                                                             : last_lane_q + LANE_W'(1);

`ifdef NO_REPEAT_LANE_EN
  assign cand_ok = in_range && (cand_lane != last_lane_q);
`else
  assign cand_ok = in_range;
`endif

  always_comb begin
    state_n     = state_q;
    retry_n     = retry_q;
    lane_n      = lane_q;
    fb_n        = fb_q;
    last_lane_n = last_lane_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_en) begin
          tmr_load = 1'b1;
          state_n  = COUNT;
        end
      end
      COUNT: begin
        if (!i_en) begin
          state_n = IDLE;
        end else if (tmr_zero) begin
          state_n = REQ;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      REQ: begin
        if (!i_en) begin
          retry_n = '0;
          state_n = IDLE;
        end else begin
          state_n = SAMPLE;
        end
      end
      SAMPLE: begin
        // The generator stepped on the edge that ended REQ, so i_rand is fresh here.
        if (!i_en) begin
          retry_n = '0;
          state_n = IDLE;
        end else if (cand_ok) begin
          lane_n  = cand_lane;
          fb_n    = 1'b0;
          retry_n = '0;
          state_n = PRESENT;
        end else if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
          lane_n  = fb_lane;
          fb_n    = 1'b1;
          retry_n = '0;
          state_n = PRESENT;
        end else begin
          retry_n = retry_q + RETRY_W'(1);
          state_n = REQ;
        end
      end
      PRESENT: begin
        // The offer is held regardless of i_en until the game FSM takes it.
        if (i_spawn_ready) begin
          last_lane_n = lane_q;
          if (i_en) begin
            tmr_load = 1'b1;
            state_n  = COUNT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      retry_q       <= '0;
      lane_q        <= '0;
      fb_q          <= 1'b0;
      last_lane_q   <= '0;
      o_rand_req    <= 1'b0;
      o_spawn_valid <= 1'b0;
    end else begin
      state_q       <= state_n;
      retry_q       <= retry_n;
      lane_q        <= lane_n;
      fb_q          <= fb_n;
      last_lane_q   <= last_lane_n;
      o_rand_req    <= (state_n == REQ);
      o_spawn_valid <= (state_n == PRESENT);
    end
  end

  assign o_spawn_lane = lane_q;
  assign o_fallback   = fb_q;

endmodule

// File: tb/tb_rand_spawn_ctrl.sv
// Directed bench for rand_spawn_ctrl driven by a model of the 4-bit LFSR (seed 3).
module tb_rand_spawn_ctrl;

  localparam int NUM_LANES    = 6;
  localparam int SPAWN_PERIOD = 20;
  localparam int MAX_RETRY    = 4;
  localparam int LANE_W       = 3;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [3:0]        rand_v;
  logic              rand_req;
  logic              spawn_valid;
  logic              spawn_ready;
  logic [LANE_W-1:0] spawn_lane;
  logic              fallback;

  logic [3:0] gen_q;
  logic       force_en;
  logic [3:0] force_val;

  int total;
  int fails;

  rand_spawn_ctrl #(
    .NUM_LANES    (NUM_LANES),
    .SPAWN_PERIOD (SPAWN_PERIOD),
    .MAX_RETRY    (MAX_RETRY),
    .LANE_W       (LANE_W)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_rand        (rand_v),
    .o_rand_req    (rand_req),
    .o_spawn_valid (spawn_valid),
    .i_spawn_ready (spawn_ready),
    .o_spawn_lane  (spawn_lane),
    .o_fallback    (fallback)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Right-shift LFSR, feedback s[3]^s[0]: 3,9,4,2,1,8,12,14,15,7,11,5,...
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) gen_q <= 4'd3;
    else if (rand_req) gen_q <= {gen_q[3] ^ gen_q[0], gen_q[3:1]};
  end

  assign rand_v = force_en ? force_val : gen_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int cyc, output int reqs);
    cyc  = 0;
    reqs = 0;
    while (cyc < max) begin
      step();
      cyc++;
      if (rand_req) reqs++;
      if (spawn_valid) break;
    end
  endtask

  task automatic wait_req(input int max, output int cyc);
    cyc = 0;
    while (cyc < max) begin
      step();
      cyc++;
      if (rand_req) break;
    end
  endtask

  task automatic check_spawn(input string tag, input int cyc, input int reqs,
                             input int exp_cyc, input int exp_reqs,
                             input int exp_lane, input int exp_fb);
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_reqs"}, reqs, exp_reqs);
    chk({tag, "_valid"}, {31'd0, spawn_valid}, 1);
    chk({tag, "_lane"}, {29'd0, spawn_lane}, exp_lane);
    chk({tag, "_fallback"}, {31'd0, fallback}, exp_fb);
  endtask

  initial begin
    int  cyc;
    int  reqs;
    int  vcnt;
    bit  stable;

    total       = 0;
    fails       = 0;
    rst_n       = 1'b0;
    en          = 1'b0;
    spawn_ready = 1'b1;
    force_en    = 1'b0;
    force_val   = 4'd0;

    repeat (3) step();
    chk("rst_req", {31'd0, rand_req}, 0);
    chk("rst_valid", {31'd0, spawn_valid}, 0);
    chk("rst_lane", {29'd0, spawn_lane}, 0);
    chk("rst_fallback", {31'd0, fallback}, 0);

    // First spawn: 9 rejected, 4 accepted -> lane 3.
    rst_n = 1'b1;
    en    = 1'b1;
    wait_valid(200, cyc, reqs);
    check_spawn("spawn1", cyc, reqs, SPAWN_PERIOD + 5, 2, 3, 0);

    step();
    chk("hs1_valid_drop", {31'd0, spawn_valid}, 0);
    wait_valid(200, cyc, reqs);
    check_spawn("spawn2", cyc, reqs, SPAWN_PERIOD + 2, 1, 1, 0);

    step();
    chk("hs2_valid_drop", {31'd0, spawn_valid}, 0);
    wait_valid(200, cyc, reqs);
    check_spawn("spawn3", cyc, reqs, SPAWN_PERIOD + 2, 1, 0, 0);

    // Fourth spawn: 8,12,14,15 rejected -> fallback lane 1; held without ready.
    step();
    spawn_ready = 1'b0;
    wait_valid(200, cyc, reqs);
    check_spawn("spawn4_fb", cyc, reqs, SPAWN_PERIOD + 8, 4, 1, 1);

    stable = 1'b1;
    reqs   = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (i == 10) en = 1'b0;
      if (rand_req) reqs++;
      if (!spawn_valid || spawn_lane != 3'd1 || !fallback) stable = 1'b0;
    end
    chk("hold_stable", {31'd0, stable}, 1);
    chk("hold_no_req", reqs, 0);

    spawn_ready = 1'b1;
    step();
    chk("hold_hs_drop", {31'd0, spawn_valid}, 0);
    reqs = 0;
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (rand_req) reqs++;
      if (spawn_valid) vcnt++;
    end
    chk("idle_no_req", reqs, 0);
    chk("idle_no_valid", vcnt, 0);

    // Abort during SAMPLE, then re-enable for a full period.
    en = 1'b1;
    wait_req(200, cyc);
    chk("abort_req_lat", cyc, SPAWN_PERIOD + 1);
    step();
    en = 1'b0;
    reqs = 0;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rand_req) reqs++;
      if (spawn_valid) vcnt++;
    end
    chk("abort_no_req", reqs, 0);
    chk("abort_no_valid", vcnt, 0);

    en = 1'b1;
    wait_req(200, cyc);
    chk("reen_req_lat", cyc, SPAWN_PERIOD + 1);
    wait_valid(200, cyc, reqs);
    check_spawn("spawn5", cyc, reqs, 4, 1, 4, 0);

    // Asynchronous reset while offering.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", {31'd0, rand_req}, 0);
    chk("async_valid", {31'd0, spawn_valid}, 0);
    chk("async_lane", {29'd0, spawn_lane}, 0);
    chk("async_fallback", {31'd0, fallback}, 0);

    // last_lane cleared by reset: all-zero samples fall back to lane 0+1.
    #2;
    force_en  = 1'b1;
    force_val = 4'd0;
    rst_n     = 1'b1;
    wait_valid(200, cyc, reqs);
    check_spawn("rst_fb", cyc, reqs, SPAWN_PERIOD + 9, 4, 1, 1);

    step();
    force_val = 4'd4;
    wait_valid(200, cyc, reqs);
    check_spawn("force4_a", cyc, reqs, SPAWN_PERIOD + 2, 1, 3, 0);

    step();
    wait_valid(200, cyc, reqs);
`ifdef NO_REPEAT_LANE_EN
    check_spawn("force4_b", cyc, reqs, SPAWN_PERIOD + 8, 4, 4, 1);
`else
    check_spawn("force4_b", cyc, reqs, SPAWN_PERIOD + 2, 1, 3, 0);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
